// File: rtl/vmem_controller_if.sv
// vmem_controller_if -- one requester's vector-access port on the vector
// memory controller. One instance is used for the vector core and one for
// the IO loader.
//
//   req   requester -> controller  access request, held until gnt
//   we    requester -> controller  1 = vector store, 0 = vector load
//   addr  requester -> controller  base word address
//   wd    requester -> controller  store data, lane i goes to addr+i
//   gnt   controller -> requester  one-cycle grant pulse
//   done  controller -> requester  one-cycle completion pulse
//   err   controller -> requester  one-cycle range-error pulse, with done
//   rd    controller -> requester  load result, held until the next load
interface vmem_controller_if #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8
);
  logic                                req;
  logic                                we;
  logic [WIDTH-1:0]                    addr;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  wd;
  logic                                gnt;
  logic                                done;
  logic                                err;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  rd;

  modport master (output req, we, addr, wd, input gnt, done, err, rd);
  modport slave  (input req, we, addr, wd, output gnt, done, err, rd);
endinterface

// File: rtl/vmem_controller.sv
// vmem_controller -- arbitrates a vector core and an IO loader onto a single
// word-wide memory. A store writes a whole vector in one cycle; a load reads
// VECTOR_WIDTH consecutive words, one per cycle, and returns them as a vector.
//
//   clk, rst      clock (rising edge), synchronous active-high reset
//   cpu, io       requester ports (vmem_controller_if, slave side)
//   mem_we        memory write enable
//   mem_addr      memory address (held while idle)
//   mem_wd        memory vector write data
//   mem_rd        memory read word, valid one cycle after mem_addr
//   mem_start_io  high in every busy cycle while the IO loader owns memory
module vmem_controller #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8,
  parameter int DEPTH        = 10000
) (
  input  logic                               clk,
  input  logic                               rst,
  vmem_controller_if.slave                   cpu,
  vmem_controller_if.slave                   io,
  output logic                               mem_we,
  output logic [WIDTH-1:0]                   mem_addr,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0]                   mem_rd,
  output logic                               mem_start_io
);

  localparam int KW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [KW-1:0]    LAST_K   = KW'(VECTOR_WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_BASE = WIDTH'(DEPTH - VECTOR_WIDTH);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_IO  = 1'b1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_t;

  state_t                             state;
  logic                               owner;
  logic                               last_owner;
  logic                               err_l;
  logic [KW-1:0]                      k;
  logic [WIDTH-1:0]                   base;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] rbuf;

  logic                               pick_io;
  logic                               any_req;
  logic                               sel_we;
  logic [WIDTH-1:0]                   sel_addr;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] sel_wd;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] load_result;

  // Round-robin: a lone requester wins; on a tie the one that did not own
  // the memory last time wins.
  always_comb begin
    any_req = cpu.req | io.req;
    if (cpu.req && io.req) pick_io = (last_owner == OWN_CPU);
    else                   pick_io = io.req;
    sel_we   = pick_io ? io.we   : cpu.we;
    sel_addr = pick_io ? io.addr : cpu.addr;
    sel_wd   = pick_io ? io.wd   : cpu.wd;
  end

  // The last lane arrives on mem_rd during WAIT and is merged straight in.
  always_comb begin
    load_result = rbuf;
    load_result[VECTOR_WIDTH-1] = mem_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_CPU;
      last_owner   <= OWN_IO;
      err_l        <= 1'b0;
      k            <= '0;
      base         <= '0;
      rbuf         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wd       <= '0;
      mem_start_io <= 1'b0;
      cpu.gnt      <= 1'b0;
      cpu.done     <= 1'b0;
      cpu.err      <= 1'b0;
      cpu.rd       <= '0;
      io.gnt       <= 1'b0;
      io.done      <= 1'b0;
      io.err       <= 1'b0;
      io.rd        <= '0;
    end else begin
      cpu.gnt  <= 1'b0;
      cpu.done <= 1'b0;
      cpu.err  <= 1'b0;
      io.gnt   <= 1'b0;
      io.done  <= 1'b0;
      io.err   <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            owner        <= pick_io;
            last_owner   <= pick_io;
            mem_start_io <= pick_io;
            base         <= sel_addr;
            k            <= '0;
            if (pick_io) io.gnt  <= 1'b1;
            else         cpu.gnt <= 1'b1;
            // Out-of-range requests still get a grant cycle (spent in WAIT)
            // but never touch memory.
            if (sel_addr > MAX_BASE) begin
              err_l <= 1'b1;
              state <= WAIT;
            end else begin
              err_l    <= 1'b0;
              mem_addr <= sel_addr;
              if (sel_we) begin
                mem_we <= 1'b1;
                mem_wd <= sel_wd;
                state  <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end

        WRITE: begin
          mem_we <= 1'b0;
          state  <= DONE;
          if (owner == OWN_IO) io.done  <= 1'b1;
          else                 cpu.done <= 1'b1;
        end

        // Cycle k presents base+k; the word for address k-1 is on mem_rd now.
        READ: begin
          if (k != '0) rbuf[k - KW'(1)] <= mem_rd;
          if (k == LAST_K) begin
            state <= WAIT;
          end else begin
            k        <= k + KW'(1);
            mem_addr <= base + WIDTH'(k) + WIDTH'(1);
          end
        end

        WAIT: begin
          state <= DONE;
          if (owner == OWN_IO) begin
            io.done <= 1'b1;
            io.err  <= err_l;
            if (!err_l) io.rd <= load_result;
          end else begin
            cpu.done <= 1'b1;
            cpu.err  <= err_l;
            if (!err_l) cpu.rd <= load_result;
          end
        end

        DONE: begin
          state        <= IDLE;
          mem_start_io <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_controller.sv
// tb_vmem_controller -- directed vectors for vmem_controller. Each request
// pushes its expected response onto a scoreboard queue; a monitor on the
// falling edge pops and compares whenever the DUT shows gnt, mem_we or done.
module tb_vmem_controller;

  typedef logic [7:0][23:0] vec_t;

  typedef struct {
    bit          is_io;
    bit          we;
    logic [23:0] base;
    vec_t        wd;
    bit          err;
    vec_t        exp_rd;
    int          lat;
    int          gap;
    logic [23:0] last_addr;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [23:0] mem_addr;
  vec_t        mem_wd;
  logic [23:0] mem_rd = '0;
  logic        mem_start_io;

  vmem_controller_if #(.WIDTH(24), .VECTOR_WIDTH(8)) cpu_bus ();
  vmem_controller_if #(.WIDTH(24), .VECTOR_WIDTH(8)) io_bus ();

  vmem_controller #(.WIDTH(24), .VECTOR_WIDTH(8), .DEPTH(10000)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (cpu_bus),
    .io           (io_bus),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd),
    .mem_start_io (mem_start_io)
  );

  always #5 clk = ~clk;

  // Memory model: word[a] = a + 0x100, one cycle read latency.
  always @(posedge clk) mem_rd <= mem_addr + 24'h100;

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  item_t sb[$];
  item_t cur;
  int    gnt_count = 0;
  int    done_count = 0;
  int    gnt_cyc = 0;
  int    last_done_cyc = -1;
  int    wcount = 0;
  bit    in_flight = 0;
  bit    io_active = 0;
  vec_t  model_cpu_rd = '0;
  vec_t  model_io_rd = '0;

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_cpu_rd = '0;
      model_io_rd  = '0;
      in_flight    = 0;
      io_active    = 0;
      wcount       = 0;
      last_done_cyc = -1;
    end else begin
      checkOutput("mem_start_io", mem_start_io, io_bus.gnt || io_active);

      if (cpu_bus.gnt || io_bus.gnt) begin
        if (cpu_bus.gnt && io_bus.gnt) checkOutput("double_gnt", 1, 0);
        if (sb.size() == 0) begin
          checkOutput("gnt_unexpected", 1, 0);
        end else begin
          checkOutput("gnt_port", io_bus.gnt, sb[0].is_io);
          if (sb[0].gap >= 0)
            checkOutput("gnt_gap", cyc - last_done_cyc, sb[0].gap);
        end
        gnt_cyc   = cyc;
        in_flight = 1;
        wcount    = 0;
        if (io_bus.gnt) io_active = 1;
        gnt_count++;
      end

      if (mem_we) begin
        if (sb.size() == 0) begin
          checkOutput("mem_we_unexpected", 1, 0);
        end else begin
          checkOutput("mem_we_allowed",
                      sb[0].we && !sb[0].err && in_flight && (cyc == gnt_cyc), 1);
          checkOutput("mem_addr_wr", mem_addr, sb[0].base);
          checkOutput("mem_wd", mem_wd, sb[0].wd);
        end
        wcount++;
      end

      if ((cpu_bus.err || io_bus.err) && !(cpu_bus.done || io_bus.done))
        checkOutput("err_without_done", 1, 0);

      if (cpu_bus.done || io_bus.done) begin
        if (cpu_bus.done && io_bus.done) checkOutput("double_done", 1, 0);
        if (sb.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          cur = sb.pop_front();
          checkOutput("done_port", io_bus.done, cur.is_io);
          checkOutput("done_in_flight", in_flight, 1);
          checkOutput("latency", cyc - gnt_cyc, cur.lat);
          checkOutput("err", {cpu_bus.err, io_bus.err},
                      cur.is_io ? {1'b0, cur.err} : {cur.err, 1'b0});
          checkOutput("write_count", wcount, (cur.we && !cur.err) ? 1 : 0);
          if (!cur.err) checkOutput("mem_addr_last", mem_addr, cur.last_addr);
          if (!cur.we && !cur.err) begin
            if (cur.is_io) model_io_rd = cur.exp_rd;
            else           model_cpu_rd = cur.exp_rd;
          end
          checkOutput("cpu_rd", cpu_bus.rd, model_cpu_rd);
          checkOutput("io_rd", io_bus.rd, model_io_rd);
        end
        last_done_cyc = cyc;
        in_flight = 0;
        if (io_bus.done) io_active = 0;
        done_count++;
      end
    end
  end

  function automatic item_t makeItem(input bit is_io, input bit we,
                                     input logic [23:0] addr, input vec_t wd,
                                     input int gap);
    item_t it;
    it.is_io = is_io;
    it.we    = we;
    it.base  = addr;
    it.wd    = wd;
    it.err   = (addr > 24'd9992);
    for (int i = 0; i < 8; i++) it.exp_rd[i] = addr + 24'(i) + 24'h100;
    it.lat       = (it.err || we) ? 1 : 9;
    it.gap       = gap;
    it.last_addr = we ? addr : addr + 24'd7;
    return it;
  endfunction

  task automatic driveReq(input bit is_io, input bit req, input bit we,
                          input logic [23:0] addr, input vec_t wd);
    if (is_io) begin
      io_bus.req = req; io_bus.we = we; io_bus.addr = addr; io_bus.wd = wd;
    end else begin
      cpu_bus.req = req; cpu_bus.we = we; cpu_bus.addr = addr; cpu_bus.wd = wd;
    end
  endtask

  task automatic applyStimulus(input bit is_io, input bit we,
                               input logic [23:0] addr, input vec_t wd);
    int start_done;
    bit seen;
    sb.push_back(makeItem(is_io, we, addr, wd, -1));
    start_done = done_count;
    @(posedge clk); #1;
    driveReq(is_io, 1'b1, we, addr, wd);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      seen = is_io ? io_bus.gnt : cpu_bus.gnt;
    end
    checkOutput("gnt_timeout", seen, 1);
    @(posedge clk); #1;
    driveReq(is_io, 1'b0, we, addr, wd);
    for (int c = 0; c < 40 && done_count == start_done; c++) begin
      @(negedge clk); #1;
    end
    checkOutput("done_timeout", done_count != start_done, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_cpu_gnt", cpu_bus.gnt, 0);
    checkOutput("rst_cpu_done", cpu_bus.done, 0);
    checkOutput("rst_cpu_err", cpu_bus.err, 0);
    checkOutput("rst_cpu_rd", cpu_bus.rd, 0);
    checkOutput("rst_io_gnt", io_bus.gnt, 0);
    checkOutput("rst_io_done", io_bus.done, 0);
    checkOutput("rst_io_err", io_bus.err, 0);
    checkOutput("rst_io_rd", io_bus.rd, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wd", mem_wd, 0);
    checkOutput("rst_mem_start_io", mem_start_io, 0);
  endtask

  function automatic vec_t seqVec(input logic [23:0] first);
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = first + 24'(i);
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   start_gnt;
    int   start_done;
    vec_t va;
    vec_t vb;

    rst = 1'b1;
    driveReq(1'b0, 1'b0, 1'b0, '0, '0);
    driveReq(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie after reset: both held, grants alternate cpu, io, cpu, io with one
    // idle cycle after each done.
    $display("[TB] tie arbitration");
    va = seqVec(24'h500);
    vb = seqVec(24'h600);
    sb.push_back(makeItem(1'b0, 1'b1, 24'h40, va, -1));
    sb.push_back(makeItem(1'b1, 1'b1, 24'h48, vb, 2));
    sb.push_back(makeItem(1'b0, 1'b1, 24'h40, va, 2));
    sb.push_back(makeItem(1'b1, 1'b1, 24'h48, vb, 2));
    start_gnt  = gnt_count;
    start_done = done_count;
    @(posedge clk); #1;
    driveReq(1'b0, 1'b1, 1'b1, 24'h40, va);
    driveReq(1'b1, 1'b1, 1'b1, 24'h48, vb);
    for (int c = 0; c < 60 && gnt_count < start_gnt + 4; c++) begin
      @(negedge clk); #1;
    end
    checkOutput("tie_gnt_count", gnt_count - start_gnt, 4);
    @(posedge clk); #1;
    driveReq(1'b0, 1'b0, 1'b1, 24'h40, va);
    driveReq(1'b1, 1'b0, 1'b1, 24'h48, vb);
    for (int c = 0; c < 40 && done_count < start_done + 4; c++) begin
      @(negedge clk); #1;
    end
    checkOutput("tie_done_count", done_count - start_done, 4);

    $display("[TB] cpu store / load");
    applyStimulus(1'b0, 1'b1, 24'h18, seqVec(24'h1));
    applyStimulus(1'b0, 1'b0, 24'h20, '0);

    $display("[TB] io store / load");
    applyStimulus(1'b1, 1'b1, 24'h20, seqVec(24'h9));
    applyStimulus(1'b1, 1'b0, 24'h30, '0);

    $display("[TB] range boundaries");
    applyStimulus(1'b1, 1'b0, 24'd9993, '0);
    applyStimulus(1'b1, 1'b0, 24'd9992, '0);
    applyStimulus(1'b0, 1'b1, 24'd9993, seqVec(24'h700));
    applyStimulus(1'b0, 1'b1, 24'd9992, seqVec(24'h800));

    // Reset in READ cycle k=4 abandons the load.
    $display("[TB] reset mid-load");
    sb.push_back(makeItem(1'b0, 1'b0, 24'h50, '0, -1));
    @(posedge clk); #1;
    driveReq(1'b0, 1'b1, 1'b0, 24'h50, '0);
    start_gnt = gnt_count;
    for (int c = 0; c < 40 && gnt_count == start_gnt; c++) begin
      @(negedge clk); #1;
    end
    checkOutput("abort_gnt", gnt_count - start_gnt, 1);
    @(posedge clk); #1;
    driveReq(1'b0, 1'b0, 1'b0, 24'h50, '0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState();
    start_done = done_count;
    repeat (12) @(negedge clk);
    checkOutput("abort_no_done", done_count - start_done, 0);
    applyStimulus(1'b0, 1'b0, 24'h60, '0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
